// File: rtl/seq_divider_64by32_if.sv
// ---------------------------------------------------------------------------
// seq_divider_64by32_if : start/done handshake and operand/result bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface seq_divider_64by32_if #(
  parameter int WIDTH = 32
) ();
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;
  logic                 overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

`default_nettype wire

// File: rtl/seq_divider_64by32.sv
// ---------------------------------------------------------------------------
// seq_divider_64by32 : restoring 2W/W divider, one quotient bit per clock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_divider_64by32 #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_divider_64by32_if.slave   bus
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   part_rem;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   divisor_reg;
  logic [CNT_W-1:0]   count;

  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   quotient_reg;
  logic [WIDTH-1:0]   remainder_reg;
  logic               dbz_reg;
  logic               ovf_reg;

  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     trial_diff;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   q_next;

  // Partial remainder stays below the divisor, so trial - divisor fits in W bits
  always_comb begin
    trial      = {part_rem, shift_q[WIDTH-1]};
    trial_diff = trial - {1'b0, divisor_reg};
    if (trial >= {1'b0, divisor_reg}) begin
      rem_next = trial_diff[WIDTH-1:0];
      q_next   = {shift_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = trial[WIDTH-1:0];
      q_next   = {shift_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      part_rem      <= '0;
      shift_q       <= '0;
      divisor_reg   <= '0;
      count         <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            divisor_reg   <= bus.divisor;
            // Quotient fits in W bits only when the upper dividend half is below the divisor
            if (bus.divisor == '0) begin
              dbz_reg  <= 1'b1;
              done_reg <= 1'b1;
              state    <= DONE;
            end else if (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
              ovf_reg  <= 1'b1;
              done_reg <= 1'b1;
              state    <= DONE;
            end else begin
              part_rem <= bus.dividend[2*WIDTH-1:WIDTH];
              shift_q  <= bus.dividend[WIDTH-1:0];
              count    <= '0;
              busy_reg <= 1'b1;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          part_rem <= rem_next;
          shift_q  <= q_next;
          count    <= count + 1'b1;
          if (count == LAST_COUNT) begin
            quotient_reg  <= q_next;
            remainder_reg <= rem_next;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          done_reg <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.overflow    = ovf_reg;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_64by32.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_64by32 : vector table + scoreboard bench for the divider
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider_64by32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_divider_64by32_if #(.WIDTH(32)) bus ();

  seq_divider_64by32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
    int          busy_cycles;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [63:0] dvd, input logic [31:0] dvs);
    vec_t m;
    logic [63:0] qq;
    logic [63:0] rr;
    m.dividend = dvd;
    m.divisor  = dvs;
    m.q = '0; m.r = '0; m.dbz = 1'b0; m.ovf = 1'b0;
    m.lat = 1; m.busy_cycles = 0;
    if (dvs == 32'd0) m.dbz = 1'b1;
    else if (dvd[63:32] >= dvs) m.ovf = 1'b1;
    else begin
      qq = dvd / {32'd0, dvs};
      rr = dvd % {32'd0, dvs};
      m.q = qq[31:0];
      m.r = rr[31:0];
      m.lat = 33;
      m.busy_cycles = 32;
    end
    return m;
  endfunction

  // disturb_at: cycle at which start is re-pulsed with other operands
  // reset_at  : cycle at which rst_n is pulsed, aborting the operation
  task automatic run_op(input vec_t v, input string nm, input int disturb_at, input int reset_at);
    vec_t e;
    int   cyc;
    int   bcnt;
    logic got;
    @(negedge clk);
    sb.push_back(v);
    bus.dividend = v.dividend;
    bus.divisor  = v.divisor;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc  = 1;
    bcnt = 0;
    got  = 1'b0;
    while (cyc <= 100 && !got) begin
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk({nm, " reset ctl"}, {60'd0, bus.busy, bus.done, bus.div_by_zero, bus.overflow}, 64'd0);
        chk({nm, " reset res"}, {bus.quotient, bus.remainder}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk({nm, " reset no done"}, {63'd0, bus.done}, 64'd0);
        rst_n = 1'b1;
        e = sb.pop_back();
        return;
      end
      if (bus.done) got = 1'b1;
      else begin
        if (bus.busy) bcnt++;
        if (cyc == disturb_at) begin
          bus.start    = 1'b1;
          bus.dividend = 64'h0000_0000_0000_1234;
          bus.divisor  = 32'd3;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      chk({nm, " done timeout"}, 64'(cyc), 64'(e.lat));
      return;
    end
    chk({nm, " quotient"},  {32'd0, bus.quotient},  {32'd0, e.q});
    chk({nm, " remainder"}, {32'd0, bus.remainder}, {32'd0, e.r});
    chk({nm, " flags"},     {62'd0, bus.div_by_zero, bus.overflow}, {62'd0, e.dbz, e.ovf});
    chk({nm, " latency"},   64'(cyc),  64'(e.lat));
    chk({nm, " busy cyc"},  64'(bcnt), 64'(e.busy_cycles));
    chk({nm, " busy@done"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    vec_t        v;
    logic [31:0] d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] recon;

    vecs[0] = '{64'd14924014882973888, 32'd121212121, 32'd123123123, 32'd5, 1'b0, 1'b0, 33, 32};
    vecs[1] = '{64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, 32};
    vecs[2] = '{64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 33, 32};
    vecs[3] = '{64'hDEAD_BEEF_0123_4567, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1, 0};
    vecs[4] = '{64'h0000_0001_0000_0000, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1, 0};
    vecs[5] = '{64'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 33, 32};

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    chk("reset ctl", {60'd0, bus.busy, bus.done, bus.div_by_zero, bus.overflow}, 64'd0);
    chk("reset res", {bus.quotient, bus.remainder}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i), 0, 0);

    // Start re-pulsed with new operands mid-calculation must be ignored
    run_op(vecs[1], "ignored start", 10, 0);

    // Reset mid-calculation, then a clean operation afterwards
    run_op(vecs[1], "abort", 0, 15);
    v = '{64'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0, 33, 32};
    run_op(v, "after reset", 0, 0);
    repeat (3) @(negedge clk);
    chk("result hold", {bus.quotient, bus.remainder}, {32'd10, 32'd0});

    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      if (d == 32'd0) d = 32'd1;
      hi = $urandom_range(d - 32'd1, 0);
      lo = $urandom;
      v  = model({hi, lo}, d);
      run_op(v, $sformatf("rand%0d", i), 0, 0);
      recon = {32'd0, bus.quotient} * {32'd0, d} + {32'd0, bus.remainder};
      chk($sformatf("rand%0d identity", i), recon, {hi, lo});
      chk($sformatf("rand%0d rem<div", i), {63'd0, (bus.remainder < d)}, 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
